// File: rtl/bilinear_downscale_core.sv
// Bilinear image resampler: reads four source neighbours per output pixel from a
// shared single-port SRAM, blends them in Q8 fixed point and writes the result back.
module bilinear_downscale_core #(
   parameter int ADDR_BITS = 8,
   parameter int DIM_BITS  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    step_mode,
   input  logic                    step_pulse,
   input  logic [ADDR_BITS-1:0]    src_base,
   input  logic [ADDR_BITS-1:0]    dst_base,
   input  logic [DIM_BITS-1:0]     src_w,
   input  logic [DIM_BITS-1:0]     src_h,
   input  logic [DIM_BITS-1:0]     dst_w,
   input  logic [DIM_BITS-1:0]     dst_h,
   input  logic [11:0]             scale_x,
   input  logic [11:0]             scale_y,
   output logic                    mem_we,
   output logic [ADDR_BITS-1:0]    mem_addr,
   output logic [7:0]              mem_wdata,
   input  logic [7:0]              mem_rdata,
   output logic                    busy,
   output logic                    done,
   output logic [2*DIM_BITS-1:0]   pix_count
);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_COORD = 4'd1;
   localparam logic [3:0] S_RD0   = 4'd2;
   localparam logic [3:0] S_RD1   = 4'd3;
   localparam logic [3:0] S_RD2   = 4'd4;
   localparam logic [3:0] S_RD3   = 4'd5;
   localparam logic [3:0] S_RD4   = 4'd6;
   localparam logic [3:0] S_CALC  = 4'd7;
   localparam logic [3:0] S_WRITE = 4'd8;
   localparam logic [3:0] S_PAUSE = 4'd9;
   localparam logic [3:0] S_FIN   = 4'd10;

   localparam logic [DIM_BITS-1:0]   ZERO_D = {DIM_BITS{1'b0}};
   localparam logic [DIM_BITS-1:0]   ONE_D  = {{(DIM_BITS-1){1'b0}}, 1'b1};
   localparam logic [2*DIM_BITS-1:0] ZERO_P = {(2*DIM_BITS){1'b0}};
   localparam logic [2*DIM_BITS-1:0] ONE_P  = {{(2*DIM_BITS-1){1'b0}}, 1'b1};
   localparam logic [ADDR_BITS-1:0]  ZERO_A = {ADDR_BITS{1'b0}};

   // Integer part of a Q4.8 position, clamped to the last valid column/row.
   function automatic logic [DIM_BITS-1:0] clamp_coord(input logic [DIM_BITS+3:0] pos,
                                                       input logic [DIM_BITS-1:0] lim);
      if (pos > {4'b0000, lim}) begin
         clamp_coord = lim;
      end else begin
         clamp_coord = pos[DIM_BITS-1:0];
      end
   endfunction

   function automatic logic [DIM_BITS-1:0] next_coord(input logic [DIM_BITS-1:0] c,
                                                      input logic [DIM_BITS-1:0] lim);
      if (c < lim) begin
         next_coord = c + ONE_D;
      end else begin
         next_coord = lim;
      end
   endfunction

   // base + row*width + col, wrapping modulo the address space.
   function automatic logic [ADDR_BITS-1:0] lin_addr(input logic [ADDR_BITS-1:0] base,
                                                     input logic [DIM_BITS-1:0]  row,
                                                     input logic [DIM_BITS-1:0]  width,
                                                     input logic [DIM_BITS-1:0]  col);
      logic [2*DIM_BITS-1:0] off;
      off      = {ZERO_D, row} * {ZERO_D, width};
      lin_addr = base + ADDR_BITS'(off) + ADDR_BITS'(col);
   endfunction

   // Weighted sum of four pixels; weights per axis sum to 256, so the rounded result fits 8 bits.
   function automatic logic [7:0] lerp2d(input logic [7:0] p00, input logic [7:0] p01,
                                         input logic [7:0] p10, input logic [7:0] p11,
                                         input logic [7:0] fx,  input logic [7:0] fy);
      logic [8:0]  fx_w, gx_w, fy_w, gy_w;
      logic [25:0] top, bot, acc;
      fx_w   = {1'b0, fx};
      fy_w   = {1'b0, fy};
      gx_w   = 9'd256 - fx_w;
      gy_w   = 9'd256 - fy_w;
      top    = 26'(p00) * 26'(gx_w) + 26'(p01) * 26'(fx_w);
      bot    = 26'(p10) * 26'(gx_w) + 26'(p11) * 26'(fx_w);
      acc    = top * 26'(gy_w) + bot * 26'(fy_w) + 26'd32768;
      lerp2d = 8'(acc >> 16);
   endfunction

   logic [3:0]            state_r;
   logic [ADDR_BITS-1:0]  src_base_r, dst_base_r;
   logic [DIM_BITS-1:0]   src_w_r, src_h_r, dst_w_r, dst_h_r;
   logic [11:0]           scale_x_r, scale_y_r;
   logic                  step_mode_r;
   logic [DIM_BITS-1:0]   ox_r, oy_r;
   logic [DIM_BITS-1:0]   x0_r, x1_r, y0_r, y1_r;
   logic [7:0]            fx_r, fy_r;
   logic [7:0]            p00_r, p01_r, p10_r, p11_r;

   logic [DIM_BITS+11:0]  sx_s, sy_s;
   logic [DIM_BITS-1:0]   xmax_s, ymax_s;
   logic [DIM_BITS-1:0]   x0_s, x1_s, y0_s, y1_s;
   logic                  last_col_s, last_pix_s;
   logic [7:0]            res_s;
   logic [ADDR_BITS-1:0]  wr_addr_s;

   // Source position of the current output pixel, neighbour coordinates and blend result.
   always_comb begin
      sx_s       = {12'h000, ox_r} * {ZERO_D, scale_x_r};
      sy_s       = {12'h000, oy_r} * {ZERO_D, scale_y_r};
      xmax_s     = src_w_r - ONE_D;
      ymax_s     = src_h_r - ONE_D;
      x0_s       = clamp_coord(sx_s[DIM_BITS+11:8], xmax_s);
      y0_s       = clamp_coord(sy_s[DIM_BITS+11:8], ymax_s);
      x1_s       = next_coord(x0_s, xmax_s);
      y1_s       = next_coord(y0_s, ymax_s);
      last_col_s = (ox_r == (dst_w_r - ONE_D));
      last_pix_s = last_col_s && (oy_r == (dst_h_r - ONE_D));
      res_s      = lerp2d(p00_r, p01_r, p10_r, p11_r, fx_r, fy_r);
      wr_addr_s  = lin_addr(dst_base_r, oy_r, dst_w_r, ox_r);
   end

   // Sequencer: one output pixel per COORD..WRITE pass, all SRAM outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= S_IDLE;
         mem_we      <= 1'b0;
         mem_addr    <= ZERO_A;
         mem_wdata   <= 8'h00;
         busy        <= 1'b0;
         done        <= 1'b0;
         pix_count   <= ZERO_P;
         ox_r        <= ZERO_D;
         oy_r        <= ZERO_D;
         src_base_r  <= ZERO_A;
         dst_base_r  <= ZERO_A;
         src_w_r     <= ZERO_D;
         src_h_r     <= ZERO_D;
         dst_w_r     <= ZERO_D;
         dst_h_r     <= ZERO_D;
         scale_x_r   <= 12'h000;
         scale_y_r   <= 12'h000;
         step_mode_r <= 1'b0;
         x0_r        <= ZERO_D;
         x1_r        <= ZERO_D;
         y0_r        <= ZERO_D;
         y1_r        <= ZERO_D;
         fx_r        <= 8'h00;
         fy_r        <= 8'h00;
         p00_r       <= 8'h00;
         p01_r       <= 8'h00;
         p10_r       <= 8'h00;
         p11_r       <= 8'h00;
      end else begin
         case (state_r)
            S_IDLE: begin
               mem_we <= 1'b0;
               if (start) begin
                  src_base_r  <= src_base;
                  dst_base_r  <= dst_base;
                  src_w_r     <= src_w;
                  src_h_r     <= src_h;
                  dst_w_r     <= dst_w;
                  dst_h_r     <= dst_h;
                  scale_x_r   <= scale_x;
                  scale_y_r   <= scale_y;
                  step_mode_r <= step_mode;
                  pix_count   <= ZERO_P;
                  ox_r        <= ZERO_D;
                  oy_r        <= ZERO_D;
                  if ((dst_w == ZERO_D) || (dst_h == ZERO_D)) begin
                     done    <= 1'b1;
                     state_r <= S_FIN;
                  end else begin
                     done    <= 1'b0;
                     busy    <= 1'b1;
                     state_r <= S_COORD;
                  end
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_COORD: begin
               x0_r     <= x0_s;
               x1_r     <= x1_s;
               y0_r     <= y0_s;
               y1_r     <= y1_s;
               fx_r     <= sx_s[7:0];
               fy_r     <= sy_s[7:0];
               mem_addr <= lin_addr(src_base_r, y0_s, src_w_r, x0_s);
               state_r  <= S_RD0;
            end
            S_RD0: begin
               mem_addr <= lin_addr(src_base_r, y0_r, src_w_r, x1_r);
               state_r  <= S_RD1;
            end
            // Read data trails its address by one cycle.
            S_RD1: begin
               p00_r    <= mem_rdata;
               mem_addr <= lin_addr(src_base_r, y1_r, src_w_r, x0_r);
               state_r  <= S_RD2;
            end
            S_RD2: begin
               p01_r    <= mem_rdata;
               mem_addr <= lin_addr(src_base_r, y1_r, src_w_r, x1_r);
               state_r  <= S_RD3;
            end
            S_RD3: begin
               p10_r   <= mem_rdata;
               state_r <= S_RD4;
            end
            S_RD4: begin
               p11_r   <= mem_rdata;
               state_r <= S_CALC;
            end
            S_CALC: begin
               mem_we    <= 1'b1;
               mem_addr  <= wr_addr_s;
               mem_wdata <= res_s;
               state_r   <= S_WRITE;
            end
            S_WRITE: begin
               mem_we    <= 1'b0;
               pix_count <= pix_count + ONE_P;
               if (last_col_s) begin
                  ox_r <= ZERO_D;
                  oy_r <= oy_r + ONE_D;
               end else begin
                  ox_r <= ox_r + ONE_D;
               end
               if (last_pix_s) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= S_FIN;
               end else if (step_mode_r) begin
                  state_r <= S_PAUSE;
               end else begin
                  state_r <= S_COORD;
               end
            end
            S_PAUSE: begin
               if (step_pulse) begin
                  state_r <= S_COORD;
               end else begin
                  state_r <= S_PAUSE;
               end
            end
            S_FIN: begin
               busy    <= 1'b0;
               state_r <= S_IDLE;
            end
            default: begin
               mem_we  <= 1'b0;
               busy    <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bilinear_downscale_core.sv
// Directed self-checking bench for bilinear_downscale_core with a behavioural SRAM and write log.
module tb_bilinear_downscale_core;

   logic        clk = 1'b0;
   logic        reset, start, step_mode, step_pulse;
   logic [7:0]  src_base, dst_base;
   logic [3:0]  src_w, src_h, dst_w, dst_h;
   logic [11:0] scale_x, scale_y;
   logic        mem_we;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata;
   logic        busy, done;
   logic [7:0]  pix_count;

   int checks   = 0;
   int failures = 0;

   logic [7:0] sram [0:255];
   logic       ld_en = 1'b0;
   logic [7:0] ld_addr = 8'h00, ld_data = 8'h00;

   logic [7:0] wl_addr [0:127];
   logic [7:0] wl_data [0:127];
   int         wr_cnt = 0;

   int rd_tbl [16] = '{0, 1, 3, 4, 2, 2, 5, 5, 6, 7, 6, 7, 8, 8, 8, 8};

   bilinear_downscale_core #(.ADDR_BITS(8), .DIM_BITS(4)) dut (
      .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step_pulse(step_pulse),
      .src_base(src_base), .dst_base(dst_base), .src_w(src_w), .src_h(src_h),
      .dst_w(dst_w), .dst_h(dst_h), .scale_x(scale_x), .scale_y(scale_y),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .done(done), .pix_count(pix_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ld_en) sram[ld_addr] <= ld_data;
      else if (mem_we) sram[mem_addr] <= mem_wdata;
      mem_rdata <= sram[mem_addr];
   end

   always @(posedge clk) begin
      if (mem_we) begin
         wl_addr[wr_cnt[6:0]] <= mem_addr;
         wl_data[wr_cnt[6:0]] <= mem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
   end

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic load_src3x3();
      logic [7:0] img [9];
      img = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd40, 8'd80, 8'd0, 8'd120, 8'd200};
      for (int i = 0; i < 9; i++) poke(8'(i), img[i]);
   endtask

   task automatic cfg(input logic [7:0] sb, input logic [7:0] db, input logic [3:0] sw,
                      input logic [3:0] sh, input logic [3:0] dw, input logic [3:0] dh,
                      input logic [11:0] scx, input logic [11:0] scy);
      src_base = sb; dst_base = db; src_w = sw; src_h = sh;
      dst_w = dw; dst_h = dh; scale_x = scx; scale_y = scy;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic pulse_step();
      @(negedge clk); step_pulse = 1'b1;
      @(negedge clk); step_pulse = 1'b0;
   endtask

   // Counts busy cycles from the current negedge until busy drops (bounded).
   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (busy && cyc < 2000) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic wait_writes(input int base, input int n, output bit ok);
      int k;
      k = 0;
      while ((wr_cnt - base) < n && k < 200) begin
         @(negedge clk);
         k++;
      end
      ok = ((wr_cnt - base) >= n);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", mem_we); end
      checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", mem_addr); end
      checks++; if (mem_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata got=%h exp=00", mem_wdata); end
      checks++; if (pix_count !== 8'd0) begin failures++; $display("FAIL reset_pix got=%0d exp=0", pix_count); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_row_interp();
      int cyc, wb;
      poke(8'h00, 8'd0); poke(8'h01, 8'd100); poke(8'h02, 8'd200); poke(8'h03, 8'd250);
      cfg(8'h00, 8'h80, 4'd4, 4'd1, 4'd2, 4'd1, 12'h180, 12'h000);
      wb = wr_cnt;
      pulse_start();
      wait_idle(cyc);
      checks++; if (cyc !== 16) begin failures++; $display("FAIL row_busy_cycles got=%0d exp=16", cyc); end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL row_done got=%b exp=1", done); end
      checks++; if (pix_count !== 8'd2) begin failures++; $display("FAIL row_pix got=%0d exp=2", pix_count); end
      checks++; if (wr_cnt - wb !== 2) begin failures++; $display("FAIL row_nwrites got=%0d exp=2", wr_cnt - wb); end
      checks++; if (wl_addr[wb] !== 8'h80 || wl_data[wb] !== 8'd0) begin
         failures++; $display("FAIL row_w0 got=%h:%0d exp=80:0", wl_addr[wb], wl_data[wb]); end
      checks++; if (wl_addr[wb+1] !== 8'h81 || wl_data[wb+1] !== 8'd150) begin
         failures++; $display("FAIL row_w1 got=%h:%0d exp=81:150", wl_addr[wb+1], wl_data[wb+1]); end
      checks++; if (sram[8'h81] !== 8'd150) begin failures++; $display("FAIL row_sram81 got=%0d exp=150", sram[8'h81]); end
   endtask

   task automatic check_2x2(input string tag, input int wb, input logic [7:0] db);
      logic [7:0] ed [4];
      logic [7:0] ea;
      ed = '{8'd0, 8'd0, 8'd0, 8'd110};
      checks++; if (wr_cnt - wb !== 4) begin failures++; $display("FAIL %s_nwrites got=%0d exp=4", tag, wr_cnt - wb); end
      for (int i = 0; i < 4; i++) begin
         ea = db + 8'(i);
         checks++;
         if (wl_addr[wb+i] !== ea || wl_data[wb+i] !== ed[i]) begin
            failures++;
            $display("FAIL %s_w%0d got=%h:%0d exp=%h:%0d", tag, i, wl_addr[wb+i], wl_data[wb+i], ea, ed[i]);
         end
      end
   endtask

   task automatic test_2d_interp();
      int cyc, wb;
      load_src3x3();
      cfg(8'h00, 8'h80, 4'd3, 4'd3, 4'd2, 4'd2, 12'h180, 12'h180);
      wb = wr_cnt;
      pulse_start();
      checks++; if (done !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL 2d_start got=busy%b,done%b exp=busy1,done0", busy, done); end
      wait_idle(cyc);
      checks++; if (cyc !== 32) begin failures++; $display("FAIL 2d_busy_cycles got=%0d exp=32", cyc); end
      check_2x2("2d", wb, 8'h80);
   endtask

   task automatic test_edge_clamp();
      int k, wb, idx;
      cfg(8'h00, 8'h80, 4'd3, 4'd3, 4'd2, 4'd2, 12'h200, 12'h200);
      wb = wr_cnt;
      pulse_start();
      k = 0;
      while (busy && k < 2000) begin
         if ((k % 8) >= 1 && (k % 8) <= 4 && k < 32) begin
            idx = (k / 8) * 4 + (k % 8) - 1;
            checks++;
            if (mem_addr !== 8'(rd_tbl[idx])) begin
               failures++; $display("FAIL clamp_rd%0d got=%h exp=%h", idx, mem_addr, 8'(rd_tbl[idx]));
            end
         end
         k++;
         @(negedge clk);
      end
      checks++; if (k !== 32) begin failures++; $display("FAIL clamp_busy_cycles got=%0d exp=32", k); end
      checks++; if (wl_addr[wb+3] !== 8'h83 || wl_data[wb+3] !== 8'd200) begin
         failures++; $display("FAIL clamp_w3 got=%h:%0d exp=83:200", wl_addr[wb+3], wl_data[wb+3]); end
   endtask

   task automatic test_step_mode();
      int wb;
      bit ok;
      cfg(8'h00, 8'h80, 4'd3, 4'd3, 4'd2, 4'd2, 12'h180, 12'h180);
      step_mode = 1'b1;
      wb = wr_cnt;
      pulse_start();
      wait_writes(wb, 1, ok);
      checks++; if (!ok) begin failures++; $display("FAIL step_first_write got=timeout exp=1 write"); end
      repeat (20) @(negedge clk);
      checks++; if (wr_cnt - wb !== 1 || busy !== 1'b1 || pix_count !== 8'd1) begin
         failures++; $display("FAIL step_pause1 got=%0d/%b/%0d exp=1/1/1", wr_cnt - wb, busy, pix_count); end
      for (int s = 1; s <= 3; s++) begin
         pulse_step();
         repeat (3) @(negedge clk);
         pulse_step();
         repeat (20) @(negedge clk);
         checks++; if (wr_cnt - wb !== 1 + s) begin
            failures++; $display("FAIL step_%0d_writes got=%0d exp=%0d", s, wr_cnt - wb, 1 + s); end
         checks++; if (busy !== (s < 3) || done !== (s == 3)) begin
            failures++; $display("FAIL step_%0d_flags got=busy%b,done%b exp=busy%b,done%b", s, busy, done, s < 3, s == 3); end
      end
      checks++; if (pix_count !== 8'd4) begin failures++; $display("FAIL step_pix got=%0d exp=4", pix_count); end
      check_2x2("step", wb, 8'h80);
      step_mode = 1'b0;
   endtask

   task automatic test_start_while_busy();
      int k, wb;
      cfg(8'h00, 8'h90, 4'd3, 4'd3, 4'd2, 4'd1, 12'h180, 12'h000);
      wb = wr_cnt;
      pulse_start();
      k = 0;
      while (busy && k < 2000) begin
         if (k == 4) begin
            start = 1'b1; dst_w = 4'd4; dst_base = 8'hA0;
         end else begin
            start = 1'b0;
         end
         k++;
         @(negedge clk);
      end
      start = 1'b0;
      checks++; if (k !== 16) begin failures++; $display("FAIL busy_start_cycles got=%0d exp=16", k); end
      checks++; if (wr_cnt - wb !== 2) begin failures++; $display("FAIL busy_start_nwrites got=%0d exp=2", wr_cnt - wb); end
      checks++; if (wl_addr[wb] !== 8'h90 || wl_addr[wb+1] !== 8'h91) begin
         failures++; $display("FAIL busy_start_addr got=%h,%h exp=90,91", wl_addr[wb], wl_addr[wb+1]); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_empty();
      int wb;
      cfg(8'h00, 8'h80, 4'd3, 4'd3, 4'd0, 4'd2, 12'h180, 12'h180);
      wb = wr_cnt;
      pulse_start();
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL empty_flags got=busy%b,done%b exp=busy0,done1", busy, done); end
      repeat (12) @(negedge clk);
      checks++; if (wr_cnt - wb !== 0) begin failures++; $display("FAIL empty_nwrites got=%0d exp=0", wr_cnt - wb); end
   endtask

   task automatic test_wrap();
      int cyc, wb;
      cfg(8'h00, 8'hFE, 4'd3, 4'd3, 4'd2, 4'd2, 12'h180, 12'h180);
      wb = wr_cnt;
      pulse_start();
      wait_idle(cyc);
      check_2x2("wrap", wb, 8'hFE);
   endtask

   task automatic test_reset_mid_run();
      int cyc, wb;
      bit ok;
      load_src3x3();
      cfg(8'h00, 8'h80, 4'd3, 4'd3, 4'd2, 4'd2, 12'h180, 12'h180);
      wb = wr_cnt;
      pulse_start();
      wait_writes(wb, 2, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rst_run_second_write got=timeout exp=2 writes"); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0 || pix_count !== 8'd0) begin
         failures++; $display("FAIL rst_run_state got=%b%b%b/%0d exp=000/0", busy, done, mem_we, pix_count); end
      reset = 1'b0;
      repeat (12) @(negedge clk);
      checks++; if (wr_cnt - wb !== 2) begin failures++; $display("FAIL rst_run_nwrites got=%0d exp=2", wr_cnt - wb); end
      wb = wr_cnt;
      pulse_start();
      wait_idle(cyc);
      checks++; if (cyc !== 32) begin failures++; $display("FAIL rst_rerun_cycles got=%0d exp=32", cyc); end
      check_2x2("rerun", wb, 8'h80);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; step_mode = 1'b0; step_pulse = 1'b0;
      cfg(8'h00, 8'h00, 4'd1, 4'd1, 4'd0, 4'd0, 12'h000, 12'h000);
      test_reset();
      test_row_interp();
      test_2d_interp();
      test_edge_clamp();
      test_step_mode();
      test_start_while_busy();
      test_empty();
      test_wrap();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
